gf180mcu_osu_sc_12t_nor_reg_bank: RTL and testbench
===================================================

# gf180mcu_osu_sc_12T_nor_reg_bank

Parametrised, registered multi-channel NOR bank for the gf180mcu OSU 12T library. It extends the single two-input NOR cell to WIDTH channels of NIN-input NOR each. Each result passes through a STAGES-deep stallable pipeline. The output register has an optional sticky (event-capture) mode and a mux-scan shift chain. It sits at the boundary between cell-level logic and digital blocks that need a timed, testable NOR reduction, such as all-quiet detectors and idle/zero flags.

## Interface
Parameters:
- WIDTH, 4, number of independent NOR channels (≥2)
- NIN, 2, inputs per channel (≥2)
- STAGES, 1, pipeline depth including the output register (1..4)
- STICKY, 0, 1 = output bits accumulate (OR-in) NOR hits until CLR

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  synchronous active-high reset
- EN  input  1  pipeline advance; 0 = every stage and valid bit hold
- CLR  input  1  clears the output register Y (sticky clear)
- SE  input  1  scan enable; output register becomes a shift chain
- SI  input  1  scan data in
- A  input  WIDTH*NIN  channel i inputs are A[i*NIN +: NIN]
- Y  output  WIDTH  registered NOR results (final stage)
- VALID  output  1  Y holds data that has traversed every stage
- SO  output  1  scan data out, equals Y[WIDTH-1]

One clock; reset is synchronous and active-high (CLK, RST).

## Operation
- Combinational function: f[i] = NOT(OR of A[i*NIN +: NIN]). This is 1 only when all NIN inputs of channel i are 0.
- Pipeline: stage 1 captures f. Stage k captures stage k-1. Y is stage STAGES. With STAGES=1, Y captures f directly.
- Valid chain: one bit per stage. On an EN cycle, v1←1 and vk←v(k-1). VALID = v[STAGES].
- Non-sticky (STICKY=0): on an EN cycle, Y ← incoming stage value.
- Sticky (STICKY=1): on an EN cycle, Y ← Y OR incoming value. A bit, once set, stays set until CLR or RST.
- CLR: Y ← 0. Inner stages and the valid chain are not affected.
- Scan (SE=1): Y ← {Y[WIDTH-2:0], SI}. Inner stages and the valid chain hold. EN and CLR are ignored.
- Update priority per edge: RST > SE > CLR > EN > hold.
- No arithmetic. All widths are exact and no bits are truncated.

## Timing
- Reset values: Y=0, VALID=0, SO=0, all inner stages 0, all valid bits 0.
- Latency: a change on A appears on Y after exactly STAGES rising edges with EN=1. EN=0 edges add no progress.
- VALID rises on the STAGES-th EN edge after reset and stays 1 until RST. CLR and SE do not drop it.
- Stall (EN=0): Y, VALID and all stages hold exactly. In sticky mode no OR-in takes place.
- CLR with EN in the same cycle: Y=0 after the edge. The incoming value is lost from Y, but inner stages still advance.
- SE with EN in the same cycle: only the scan shift happens. The pipeline does not advance and no data is lost from inner stages.
- RST mid-pipeline: the next edge zeros everything regardless of EN, SE or CLR.
- SO is combinational from Y[WIDTH-1] and has no extra register. The scan chain length is WIDTH.

## Test plan
Defaults unless noted: WIDTH=4, NIN=2, STAGES=2.
- Reset/latency: RST 1 cycle, then EN=1, A=8'h00. Y=4'h0 and VALID=0 after edge 1. Y=4'hF and VALID=1 after edge 2.
- Per-channel function: A=8'b00_01_10_00 with EN held. Two edges later Y=4'b1001. Exhaustively sweep all 256 A values against the model, checking Y two EN edges later.
- Stall: after Y=4'hF, set A=8'hFF and toggle EN=0 for 5 cycles, then EN=1. Y stays 4'hF during the stall and becomes 4'h0 exactly 2 EN edges later.
- Sticky (STICKY=1): pulse a 1-cycle all-zero on channel 0 only, then return to A=8'hFF. Y[0]=1 persists for 10+ cycles. CLR → Y=0 next edge. CLR together with an EN hit → Y=0.
- Scan: load Y=4'b1010, SE=1, SI sequence 1,1,0,0. SO sequence 1,0,1,0 before each edge, final Y=4'b1100. Inner stages are unchanged: with SE=0, EN=1, the next edge shows the held stage-1 value.
- Priority: assert RST, SE, CLR and EN together. All outputs are 0 after the edge.

Source files
------------

// File: rtl/gf180mcu_osu_sc_12t_nor_reg_bank_if.sv
// Bus bundle for the registered NOR bank: pipeline/scan controls, channel
// inputs and registered results. Clock and reset stay outside the bundle.
interface gf180mcu_osu_sc_12t_nor_reg_bank_if #(
   parameter int WIDTH = 4,
   parameter int NIN   = 2
);
   logic                   EN;
   logic                   CLR;
   logic                   SE;
   logic                   SI;
   logic [WIDTH*NIN-1:0]   A;
   logic [WIDTH-1:0]       Y;
   logic                   VALID;
   logic                   SO;

   modport master (output EN, CLR, SE, SI, A, input Y, VALID, SO);
   modport slave  (input EN, CLR, SE, SI, A, output Y, VALID, SO);
endinterface

// File: rtl/gf180mcu_osu_sc_12t_nor_reg_bank.sv
// WIDTH-channel NIN-input NOR bank with a STAGES-deep stallable pipeline.
// The final stage is the output register, which can accumulate hits (STICKY)
// and doubles as a WIDTH-long mux-scan shift chain.
module gf180mcu_osu_sc_12t_nor_reg_bank #(
   parameter int WIDTH  = 4,
   parameter int NIN    = 2,
   parameter int STAGES = 1,
   parameter int STICKY = 0
) (
   input  logic CLK,
   input  logic RST,
   gf180mcu_osu_sc_12t_nor_reg_bank_if.slave bus
);

   logic [WIDTH-1:0]  f;
   logic [WIDTH-1:0]  y_in;
   logic [WIDTH-1:0]  y_q, y_d;
   logic [STAGES-1:0] vld_q, vld_d;
   logic              advance;

   // Scan mode freezes everything except the output register.
   assign advance = bus.EN & ~bus.SE;

   // Per-channel NOR reduction.
   always_comb begin
      f = '0;
      for (int i = 0; i < WIDTH; i++) begin
         f[i] = ~|bus.A[i*NIN +: NIN];
      end
   end

   generate
      if (STAGES > 1) begin : g_pipe
         logic [WIDTH-1:0] pipe_q [STAGES-1];

         // Inner stages shift forward on every non-scan EN edge.
         always_ff @(posedge CLK) begin
            if (RST) begin
               for (int k = 0; k < STAGES-1; k++) begin
                  pipe_q[k] <= '0;
               end
            end else if (advance) begin
               pipe_q[0] <= f;
               for (int k = 1; k < STAGES-1; k++) begin
                  pipe_q[k] <= pipe_q[k-1];
               end
            end
         end

         assign y_in = pipe_q[STAGES-2];
      end else begin : g_direct
         assign y_in = f;
      end
   endgenerate

   // Output register next state: scan > clear > advance > hold.
   always_comb begin
      y_d = y_q;
      if (bus.SE) begin
         y_d = {y_q[WIDTH-2:0], bus.SI};
      end else if (bus.CLR) begin
         y_d = '0;
      end else if (bus.EN) begin
         y_d = (STICKY != 0) ? (y_q | y_in) : y_in;
      end
   end

   // Valid chain follows the data; CLR does not touch it.
   always_comb begin
      vld_d = vld_q;
      if (advance) begin
         vld_d[0] = 1'b1;
         for (int k = 1; k < STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
         end
      end
   end

   // Output and valid registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         y_q   <= '0;
         vld_q <= '0;
      end else begin
         y_q   <= y_d;
         vld_q <= vld_d;
      end
   end

   assign bus.Y     = y_q;
   assign bus.VALID = vld_q[STAGES-1];
   assign bus.SO    = y_q[WIDTH-1];

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_nor_reg_bank.sv
// Bench for the NOR register bank: one non-sticky and one sticky instance
// (WIDTH=4, NIN=2, STAGES=2) share stimulus and are compared every cycle
// against a queue-based reference model, plus directed literal checks.
module tb_gf180mcu_osu_sc_12t_nor_reg_bank;
   localparam int WIDTH  = 4;
   localparam int NIN    = 2;
   localparam int STAGES = 2;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   logic en = 1'b0, clr = 1'b0, se = 1'b0, si = 1'b0;
   logic [WIDTH*NIN-1:0] a = '0;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   always #5 CLK = ~CLK;

   gf180mcu_osu_sc_12t_nor_reg_bank_if #(.WIDTH(WIDTH), .NIN(NIN)) bus_n ();
   gf180mcu_osu_sc_12t_nor_reg_bank_if #(.WIDTH(WIDTH), .NIN(NIN)) bus_s ();

   assign bus_n.EN = en;  assign bus_n.CLR = clr; assign bus_n.SE = se;
   assign bus_n.SI = si;  assign bus_n.A = a;
   assign bus_s.EN = en;  assign bus_s.CLR = clr; assign bus_s.SE = se;
   assign bus_s.SI = si;  assign bus_s.A = a;

   gf180mcu_osu_sc_12t_nor_reg_bank #(.WIDTH(WIDTH), .NIN(NIN), .STAGES(STAGES), .STICKY(0))
      dut_n (.CLK(CLK), .RST(RST), .bus(bus_n));
   gf180mcu_osu_sc_12t_nor_reg_bank #(.WIDTH(WIDTH), .NIN(NIN), .STAGES(STAGES), .STICKY(1))
      dut_s (.CLK(CLK), .RST(RST), .bus(bus_s));

   // ---------------- reference model ----------------
   logic [WIDTH-1:0] m_inner[$];
   logic [WIDTH-1:0] m_y  = '0;
   logic [WIDTH-1:0] m_ys = '0;
   int               m_cnt = 0;

   function automatic logic [WIDTH-1:0] nor_ref(logic [WIDTH*NIN-1:0] v);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) r[i] = (v[i*NIN +: NIN] == '0);
      return r;
   endfunction

   task automatic model_reset();
      m_inner.delete();
      for (int k = 0; k < STAGES-1; k++) m_inner.push_front('0);
      m_y = '0; m_ys = '0; m_cnt = 0;
   endtask

   initial model_reset();

   always @(posedge CLK) begin
      logic [WIDTH-1:0] yin;
      if (RST) begin
         model_reset();
      end else if (se) begin
         m_y  = {m_y[WIDTH-2:0], si};
         m_ys = {m_ys[WIDTH-2:0], si};
      end else begin
         yin = '0;
         if (en) begin
            yin = m_inner[$];
            void'(m_inner.pop_back());
            m_inner.push_front(nor_ref(a));
            m_cnt++;
         end
         if (clr) begin
            m_y = '0; m_ys = '0;
         end else if (en) begin
            m_y  = yin;
            m_ys = m_ys | yin;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, sampled on the falling edge.
   always @(negedge CLK) begin
      if (chk_en) begin
         check("model_Y",       32'(bus_n.Y),     32'(m_y));
         check("model_VALID",   32'(bus_n.VALID), 32'(m_cnt >= STAGES));
         check("model_SO",      32'(bus_n.SO),    32'(m_y[WIDTH-1]));
         check("model_Y_st",    32'(bus_s.Y),     32'(m_ys));
         check("model_VALID_st",32'(bus_s.VALID), 32'(m_cnt >= STAGES));
         check("model_SO_st",   32'(bus_s.SO),    32'(m_ys[WIDTH-1]));
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      // Reset / latency
      #1;
      RST = 1'b1; step();
      RST = 1'b0;
      chk_en = 1'b1;
      check("rst_Y", 32'(bus_n.Y), 32'h0);
      check("rst_VALID", 32'(bus_n.VALID), 32'h0);
      check("rst_SO", 32'(bus_n.SO), 32'h0);
      en = 1'b1; a = 8'h00;
      step();
      check("lat_e1_Y", 32'(bus_n.Y), 32'h0);
      check("lat_e1_VALID", 32'(bus_n.VALID), 32'h0);
      step();
      check("lat_e2_Y", 32'(bus_n.Y), 32'hF);
      check("lat_e2_VALID", 32'(bus_n.VALID), 32'h1);

      // Per-channel function
      a = 8'b00_01_10_00;
      step(); step();
      check("func_1001", 32'(bus_n.Y), 32'b1001);

      // Exhaustive sweep, checked by the model
      for (int v = 0; v < 256; v++) begin
         a = 8'(v);
         step();
      end

      // Stall
      a = 8'h00; step(); step();
      check("stall_pre", 32'(bus_n.Y), 32'hF);
      a = 8'hFF; en = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         check("stall_hold", 32'(bus_n.Y), 32'hF);
      end
      en = 1'b1;
      step();
      check("stall_e1", 32'(bus_n.Y), 32'hF);
      step();
      check("stall_e2", 32'(bus_n.Y), 32'h0);

      // Sticky capture
      clr = 1'b1; step(); clr = 1'b0;
      check("st_clr0", 32'(bus_s.Y), 32'h0);
      step(); step();
      check("st_quiet", 32'(bus_s.Y), 32'h0);
      a = 8'hFC; step();
      a = 8'hFF; step();
      check("st_hit", 32'(bus_s.Y), 32'b0001);
      for (int c = 0; c < 10; c++) begin
         step();
         check("st_persist", 32'(bus_s.Y), 32'b0001);
      end
      clr = 1'b1; step();
      check("st_clr", 32'(bus_s.Y), 32'h0);
      a = 8'h00; step();
      check("st_clr_en_hit", 32'(bus_s.Y), 32'h0);
      clr = 1'b0; a = 8'hFF; step();
      check("st_after_clr", 32'(bus_s.Y), 32'hF);

      // Scan
      a = 8'h33; step(); step();
      check("scan_load", 32'(bus_n.Y), 32'b1010);
      a = 8'hC0; step();
      check("scan_load2", 32'(bus_n.Y), 32'b1010);
      a = 8'hFF; se = 1'b1; en = 1'b1;
      begin
         logic [3:0] si_seq, so_exp;
         si_seq = 4'b1100;
         so_exp = 4'b1010;
         for (int c = 0; c < 4; c++) begin
            si = si_seq[3-c];
            #1;
            check("scan_SO", 32'(bus_n.SO), 32'(so_exp[3-c]));
            step();
         end
      end
      check("scan_final", 32'(bus_n.Y), 32'b1100);
      se = 1'b0; si = 1'b0;
      step();
      check("scan_held_stage", 32'(bus_n.Y), 32'b0111);

      // Priority: RST wins over everything
      RST = 1'b1; se = 1'b1; clr = 1'b1; en = 1'b1; si = 1'b1;
      step();
      check("prio_Y", 32'(bus_n.Y), 32'h0);
      check("prio_VALID", 32'(bus_n.VALID), 32'h0);
      check("prio_SO", 32'(bus_n.SO), 32'h0);
      check("prio_Y_st", 32'(bus_s.Y), 32'h0);
      RST = 1'b0; se = 1'b0; clr = 1'b0; si = 1'b0;

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         a   = 8'($urandom);
         en  = ($urandom_range(0, 3) != 0);
         se  = ($urandom_range(0, 7) == 0);
         clr = ($urandom_range(0, 9) == 0);
         si  = 1'($urandom);
         RST = ($urandom_range(0, 63) == 0);
         step();
      end
      RST = 1'b0; en = 1'b0; se = 1'b0; clr = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
